// File: rtl/port_io_bridge.sv
// rtl/port_io_bridge.sv - host-side bridge for CPU In_port/int and Out_port
// Ingress FIFO feeds one byte at a time to the CPU with an interrupt pulse; egress FIFO captures OUT writes.
module port_io_bridge #(
   parameter int DEPTH     = 4,
   parameter int INT_PULSE = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              host_in_data,
   input  logic                    host_in_valid,
   output logic                    host_in_ready,
   output logic [7:0]              host_out_data,
   output logic                    host_out_valid,
   input  logic                    host_out_ready,
   output logic [7:0]              cpu_in_port,
   output logic                    cpu_int,
   input  logic                    cpu_in_ack,
   input  logic [7:0]              cpu_out_port,
   input  logic                    cpu_out_stb,
   input  logic                    cpu_hlt,
   output logic                    egress_ovf,
   output logic [$clog2(DEPTH):0]  ingress_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
   localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LOAD = CW'(INT_PULSE - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [7:0]    in_mem_q [DEPTH];
   logic [AW:0]   in_wr_q, in_rd_q, in_lvl_q;
   logic          in_empty, in_full, in_push, in_pop;

   logic [7:0]    eg_mem_q [DEPTH];
   logic [AW:0]   eg_wr_q, eg_rd_q;
   logic          eg_empty, eg_full, eg_push, eg_pop, ovf_q;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          int_q, int_d;
   logic [7:0]    port_q, port_d;

   assign in_empty = (in_wr_q == in_rd_q);
   assign in_full  = (in_wr_q[AW] != in_rd_q[AW]) && (in_wr_q[AW-1:0] == in_rd_q[AW-1:0]);
   assign in_push  = host_in_valid & ~in_full;

   assign eg_empty = (eg_wr_q == eg_rd_q);
   assign eg_full  = (eg_wr_q[AW] != eg_rd_q[AW]) && (eg_wr_q[AW-1:0] == eg_rd_q[AW-1:0]);
   assign eg_pop   = ~eg_empty & host_out_ready;
   // A full egress can still take a strobe when the host frees a slot on the same edge.
   assign eg_push  = cpu_out_stb & (~eg_full | eg_pop);

   assign host_in_ready  = ~in_full;
   assign host_out_valid = ~eg_empty;
   assign host_out_data  = eg_empty ? 8'h00 : eg_mem_q[eg_rd_q[AW-1:0]];
   assign cpu_in_port    = port_q;
   assign cpu_int        = int_q;
   assign egress_ovf     = ovf_q;
   assign ingress_level  = in_lvl_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      int_d   = int_q;
      port_d  = port_q;
      in_pop  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!in_empty && !cpu_hlt) begin
               port_d  = in_mem_q[in_rd_q[AW-1:0]];
               int_d   = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = S_PULSE;
            end
         end
         S_PULSE: begin
            if (cpu_in_ack) begin
               in_pop  = 1'b1;
               int_d   = 1'b0;
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               int_d   = 1'b0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_WAIT: begin
            if (cpu_in_ack) begin
               in_pop  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            int_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         int_q   <= 1'b0;
         port_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         int_q   <= int_d;
         port_q  <= port_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_wr_q  <= '0;
         in_rd_q  <= '0;
         in_lvl_q <= '0;
      end else begin
         if (in_push) in_wr_q <= in_wr_q + PTR_ONE;
         if (in_pop)  in_rd_q <= in_rd_q + PTR_ONE;
         case ({in_push, in_pop})
            2'b10:   in_lvl_q <= in_lvl_q + PTR_ONE;
            2'b01:   in_lvl_q <= in_lvl_q - PTR_ONE;
            default: in_lvl_q <= in_lvl_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eg_wr_q <= '0;
         eg_rd_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (eg_push) eg_wr_q <= eg_wr_q + PTR_ONE;
         if (eg_pop)  eg_rd_q <= eg_rd_q + PTR_ONE;
         if (cpu_out_stb && !eg_push) ovf_q <= 1'b1;
      end
   end

   // Storage carries no reset: pointers define validity, stale contents are never observed.
   always_ff @(posedge clk) begin
      if (in_push) in_mem_q[in_wr_q[AW-1:0]] <= host_in_data;
      if (eg_push) eg_mem_q[eg_wr_q[AW-1:0]] <= cpu_out_port;
   end

endmodule

// File: tb/tb_port_io_bridge.sv
// tb/tb_port_io_bridge.sv - scoreboard bench for port_io_bridge
// Expected bytes are queued at stimulus time; a negedge monitor checks presentations and egress pops.
module tb_port_io_bridge;

   localparam int DEPTH     = 4;
   localparam int INT_PULSE = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] host_in_data;
   logic       host_in_valid;
   logic       host_in_ready;
   logic [7:0] host_out_data;
   logic       host_out_valid;
   logic       host_out_ready;
   logic [7:0] cpu_in_port;
   logic       cpu_int;
   logic       cpu_in_ack;
   logic [7:0] cpu_out_port;
   logic       cpu_out_stb;
   logic       cpu_hlt;
   logic       egress_ovf;
   logic [2:0] ingress_level;

   port_io_bridge #(.DEPTH(DEPTH), .INT_PULSE(INT_PULSE)) dut (
      .clk            (clk),
      .rst            (rst),
      .host_in_data   (host_in_data),
      .host_in_valid  (host_in_valid),
      .host_in_ready  (host_in_ready),
      .host_out_data  (host_out_data),
      .host_out_valid (host_out_valid),
      .host_out_ready (host_out_ready),
      .cpu_in_port    (cpu_in_port),
      .cpu_int        (cpu_int),
      .cpu_in_ack     (cpu_in_ack),
      .cpu_out_port   (cpu_out_port),
      .cpu_out_stb    (cpu_out_stb),
      .cpu_hlt        (cpu_hlt),
      .egress_ovf     (egress_ovf),
      .ingress_level  (ingress_level)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         mdl_in = 0;
   int         mdl_eg = 0;
   logic [7:0] exp_in_q[$];
   logic [7:0] exp_eg_q[$];
   logic       prev_int = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event not seen / unexpected", name);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (host_out_valid && host_out_ready) begin
            if (exp_eg_q.size() == 0) fail_now("egress_unexpected_pop");
            else chk("egress_data", int'(host_out_data), int'(exp_eg_q.pop_front()));
         end
         if (cpu_int && !prev_int) begin
            if (exp_in_q.size() == 0) fail_now("ingress_unexpected_present");
            else chk("cpu_in_port", int'(cpu_in_port), int'(exp_in_q.pop_front()));
         end
      end
      prev_int = cpu_int;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_push(input logic [7:0] b);
      chk("host_in_ready", int'(host_in_ready), (mdl_in < DEPTH) ? 1 : 0);
      if (mdl_in < DEPTH) begin
         exp_in_q.push_back(b);
         mdl_in++;
      end
      host_in_data  = b;
      host_in_valid = 1'b1;
      tick();
      host_in_valid = 1'b0;
   endtask

   task automatic present_and_ack(input string tag);
      int w = 0;
      int n = 0;
      while (!cpu_int && w < 20) begin
         tick();
         w++;
      end
      if (!cpu_int) fail_now({tag, "_int_timeout"});
      while (cpu_int && n < 20) begin
         n++;
         tick();
      end
      chk({tag, "_int_len"}, n, INT_PULSE);
      cpu_in_ack = 1'b1;
      tick();
      cpu_in_ack = 1'b0;
      mdl_in--;
      chk({tag, "_level"}, int'(ingress_level), mdl_in);
   endtask

   task automatic out_strobe(input logic [7:0] b, input logic rdy);
      int pop;
      pop = (rdy && mdl_eg > 0) ? 1 : 0;
      if (mdl_eg < DEPTH || pop == 1) begin
         exp_eg_q.push_back(b);
         mdl_eg = mdl_eg - pop + 1;
      end else begin
         mdl_eg = mdl_eg - pop;
      end
      host_out_ready = rdy;
      cpu_out_port   = b;
      cpu_out_stb    = 1'b1;
      tick();
      cpu_out_stb    = 1'b0;
      host_out_ready = 1'b0;
   endtask

   task automatic drain(input int n);
      host_out_ready = 1'b1;
      repeat (n) tick();
      host_out_ready = 1'b0;
      mdl_eg -= n;
   endtask

   initial begin
      int w;
      int hi;
      rst = 1'b0;
      host_in_data = 8'h00;  host_in_valid = 1'b0;  host_out_ready = 1'b0;
      cpu_in_ack = 1'b0;     cpu_out_port = 8'h00;  cpu_out_stb = 1'b0;  cpu_hlt = 1'b0;
      repeat (2) tick();
      chk("rst_int", int'(cpu_int), 0);
      chk("rst_in_port", int'(cpu_in_port), 0);
      chk("rst_in_ready", int'(host_in_ready), 1);
      chk("rst_out_valid", int'(host_out_valid), 0);
      chk("rst_out_data", int'(host_out_data), 0);
      chk("rst_level", int'(ingress_level), 0);
      chk("rst_ovf", int'(egress_ovf), 0);
      rst = 1'b1;
      tick();

      // two bytes, interrupt pulse per byte, one idle cycle between presentations
      host_push(8'h11);
      chk("t1_level1", int'(ingress_level), 1);
      host_push(8'h22);
      chk("t1_level2", int'(ingress_level), 2);
      present_and_ack("t1a");
      w = 0;
      while (!cpu_int && w < 20) begin
         tick();
         w++;
      end
      chk("t1_gap", w, 1);
      present_and_ack("t1b");
      chk("t1_hold_port", int'(cpu_in_port), 8'h22);
      repeat (2) tick();

      // fill ingress while halted, overflowing push rejected, drain in order
      cpu_hlt = 1'b1;
      for (int i = 0; i < 5; i++) host_push(8'h31 + 8'(i));
      chk("t2_level_full", int'(ingress_level), 4);
      chk("t2_ready_full", int'(host_in_ready), 0);
      cpu_hlt = 1'b0;
      for (int i = 0; i < 4; i++) present_and_ack("t2");
      repeat (2) tick();

      // halt blocks presentation until released
      cpu_hlt = 1'b1;
      host_push(8'h5A);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (cpu_int) hi++;
         tick();
      end
      chk("t3_hlt_no_int", hi, 0);
      cpu_hlt = 1'b0;
      tick();
      chk("t3_int_after_release", int'(cpu_int), 1);
      present_and_ack("t3");
      repeat (2) tick();

      // egress basic
      out_strobe(8'hA1, 1'b0);
      out_strobe(8'hB2, 1'b0);
      chk("t4_valid", int'(host_out_valid), 1);
      chk("t4_head", int'(host_out_data), 8'hA1);
      drain(2);
      chk("t4_empty", int'(host_out_valid), 0);

      // egress full: coincident pop accepted, then a drop sets sticky overflow
      for (int i = 1; i <= 4; i++) out_strobe(8'(i), 1'b0);
      chk("t5_no_ovf_full", int'(egress_ovf), 0);
      out_strobe(8'h05, 1'b1);
      chk("t5_no_ovf_coincident", int'(egress_ovf), 0);
      out_strobe(8'h06, 1'b0);
      chk("t5_ovf_set", int'(egress_ovf), 1);
      drain(4);
      chk("t5_empty", int'(host_out_valid), 0);
      chk("t5_ovf_sticky", int'(egress_ovf), 1);

      chk("sb_ingress_left", exp_in_q.size(), 0);
      chk("sb_egress_left", exp_eg_q.size(), 0);

      // asynchronous reset in the middle of an interrupt pulse
      out_strobe(8'h99, 1'b0);
      host_push(8'h77);
      w = 0;
      while (!cpu_int && w < 20) begin
         tick();
         w++;
      end
      if (!cpu_int) fail_now("t6_int_timeout");
      #2 rst = 1'b0;
      #1;
      chk("t6_int_async", int'(cpu_int), 0);
      chk("t6_level", int'(ingress_level), 0);
      chk("t6_ovf", int'(egress_ovf), 0);
      chk("t6_out_valid", int'(host_out_valid), 0);
      chk("t6_in_ready", int'(host_in_ready), 1);
      exp_in_q.delete();
      exp_eg_q.delete();
      mdl_in = 0;
      mdl_eg = 0;
      tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("t6_post_int", int'(cpu_int), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
